// File: rtl/uart_rx_frame.sv
// 8E1 UART receiver: 2-flop synced RxD, OVERSAMPLE-x ticks, mid-bit sampling; Rx_VALID strobes 1 clk
// after the stop sample (168 ticks after the start edge). No backpressure: each strobe must be taken.
module uart_rx_frame #(
  parameter int OVERSAMPLE = 16,
  parameter int CLK_HZ     = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_VALID
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(OVERSAMPLE - 1);

  // Rounded clk/(OVERSAMPLE*baud); at 100 MHz this gives 20833,5208,1302,651,326,163,109,54.
  function automatic logic [14:0] div_for(input int baud);
    int d;
    d = (CLK_HZ + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
    if (d < 1) d = 1;
    return 15'(d);
  endfunction

  localparam logic [14:0] DIV0 = div_for(300);
  localparam logic [14:0] DIV1 = div_for(1200);
  localparam logic [14:0] DIV2 = div_for(4800);
  localparam logic [14:0] DIV3 = div_for(9600);
  localparam logic [14:0] DIV4 = div_for(19200);
  localparam logic [14:0] DIV5 = div_for(38400);
  localparam logic [14:0] DIV6 = div_for(57600);
  localparam logic [14:0] DIV7 = div_for(115200);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nx;
  logic          rx_meta, rxs, rxs_d;
  logic [14:0]   div_val, div_cnt;
  logic          tick, bit_tick, fall;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          perr, vld_q;
  logic          start_det, smp_start_ok, smp_data, smp_par, smp_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign fall = rxs_d & ~rxs;

  always_comb begin
    div_val = DIV0;
    case (baud_select)
      3'd0: div_val = DIV0;
      3'd1: div_val = DIV1;
      3'd2: div_val = DIV2;
      3'd3: div_val = DIV3;
      3'd4: div_val = DIV4;
      3'd5: div_val = DIV5;
      3'd6: div_val = DIV6;
      default: div_val = DIV7;
    endcase
  end

  // >= rather than == so a mid-frame baud change to a smaller divisor cannot strand the counter.
  assign tick = Rx_EN && (div_cnt >= div_val - 15'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             div_cnt <= '0;
    else if (!Rx_EN || start_det || tick)  div_cnt <= '0;
    else                                   div_cnt <= div_cnt + 15'd1;
  end

  assign bit_tick = tick && (tick_cnt == ((state == START) ? MID_LAST : BIT_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        tick_cnt <= '0;
    else if (!Rx_EN || state == IDLE) tick_cnt <= '0;
    else if (bit_tick)                tick_cnt <= '0;
    else if (tick)                    tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!Rx_EN) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (fall) state_nx = START;
        START:   if (bit_tick) state_nx = rxs ? IDLE : DATA;
        DATA:    if (bit_tick && bit_cnt == 3'd7) state_nx = PARITY;
        PARITY:  if (bit_tick) state_nx = STOP;
        STOP:    if (bit_tick) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    start_det    = (state == IDLE) && Rx_EN && fall;
    smp_start_ok = (state == START) && bit_tick && !rxs;
    smp_data     = (state == DATA) && bit_tick;
    smp_par      = (state == PARITY) && bit_tick;
    smp_stop     = (state == STOP) && bit_tick;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      perr      <= 1'b0;
      Rx_DATA   <= 8'h00;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (start_det) begin
        Rx_PERROR <= 1'b0;
        Rx_FERROR <= 1'b0;
      end
      if (smp_start_ok) bit_cnt <= '0;
      if (smp_data) begin
        shreg[bit_cnt] <= rxs;
        bit_cnt        <= bit_cnt + 3'd1;
      end
      if (smp_par) perr <= (^shreg) ^ rxs;
      if (smp_stop) begin
        Rx_DATA   <= shreg;
        Rx_PERROR <= perr;
        Rx_FERROR <= ~rxs;
        vld_q     <= ~perr & rxs;
      end
    end
  end

  // Dropping the enable suppresses a strobe already registered in the same cycle.
  assign Rx_VALID = vld_q & Rx_EN;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: frame-level model (byte, parity, stop -> expected outputs and strobe window)
// checked every clock, plus literal expectations for the directed scenarios.
module tb_uart_rx_frame;
  localparam int CLK_HZ = 3_200_000;

  logic       clk = 1'b0;
  logic       reset, Rx_EN, RxD;
  logic [2:0] baud_select;
  logic [7:0] Rx_DATA;
  logic       Rx_PERROR, Rx_FERROR, Rx_VALID;

  uart_rx_frame #(.OVERSAMPLE(16), .CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .RxD(RxD),
    .Rx_DATA(Rx_DATA), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR), .Rx_VALID(Rx_VALID)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  // Model of the observable outputs and of the window where a strobe may appear.
  logic [7:0] m_data = 8'h00;
  logic       m_perr = 1'b0, m_ferr = 1'b0;
  int         hold_until = -1;
  int         vld_lo = -1, vld_hi = -1, vld_seen = 0, vld_cyc = 0, last_t0 = 0;
  logic       vld_exp = 1'b0;
  logic [7:0] vld_byte = 8'h00;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int baud_div(input int sel);
    int  bauds[8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
    real r;
    r = real'(CLK_HZ) / (16.0 * real'(bauds[sel]));
    return $rtoi(r + 0.5);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc > hold_until) begin
        check("data", {24'h0, Rx_DATA}, {24'h0, m_data});
        check("perr", {31'h0, Rx_PERROR}, {31'h0, m_perr});
        check("ferr", {31'h0, Rx_FERROR}, {31'h0, m_ferr});
      end
      if (cyc >= vld_lo && cyc <= vld_hi) begin
        if (Rx_VALID) begin
          vld_seen++;
          vld_cyc = cyc;
          check("vld_data", {24'h0, Rx_DATA}, {24'h0, vld_byte});
          check("vld_flags", {30'h0, Rx_PERROR, Rx_FERROR}, 32'h0);
        end
      end else begin
        check("vld_idle", {31'h0, Rx_VALID}, 32'h0);
      end
      if (cyc == vld_hi + 1) check("vld_count", vld_seen, {31'h0, vld_exp});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called when the bench makes a falling edge the receiver will see while idle and enabled.
  task automatic mark_start();
    m_perr = 1'b0;
    m_ferr = 1'b0;
    if (hold_until < cyc + 6) hold_until = cyc + 6;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s, input int div);
    logic [10:0] bits;
    int          t0;
    bits = {s, p, b, 1'b0};
    t0   = cyc;
    for (int i = 0; i < 11; i++) begin
      RxD = bits[i];
      if (i == 0) mark_start();
      if (i == 10) begin
        hold_until = t0 + 169 * div + 6;
        m_data     = b;
        m_perr     = (^b) ^ p;
        m_ferr     = ~s;
        vld_lo     = t0 + 167 * div;
        vld_hi     = t0 + 169 * div + 6;
        vld_exp    = ~m_perr & s;
        vld_byte   = b;
        vld_seen   = 0;
        last_t0    = t0;
      end
      step(16 * div);
    end
  endtask

  // Start bit, bits 0..3, then half of bit 4; the caller aborts the frame.
  task automatic send_partial(input logic [7:0] b, input int div);
    RxD = 1'b0;
    mark_start();
    step(16 * div);
    for (int i = 0; i < 4; i++) begin
      RxD = b[i];
      step(16 * div);
    end
    RxD = b[4];
    step(8 * div);
  endtask

  int d96, d115;

  initial begin
    reset = 1'b1; Rx_EN = 1'b0; RxD = 1'b1; baud_select = 3'd3;
    d96  = baud_div(3);
    d115 = baud_div(7);
    step(3);
    mon_en = 1'b1;
    check("rst_data", {24'h0, Rx_DATA}, 32'h0);
    check("rst_flags", {30'h0, Rx_PERROR, Rx_FERROR}, 32'h0);
    reset = 1'b0; Rx_EN = 1'b1;
    step(400);
    check("idle_valid", {31'h0, Rx_VALID}, 32'h0);

    send_frame(8'hA5, 1'b0, 1'b1, d96);
    check("a5_data", {24'h0, Rx_DATA}, 32'hA5);
    check("a5_flags", {30'h0, Rx_PERROR, Rx_FERROR}, 32'h0);
    check("a5_strobes", vld_seen, 32'd1);
    check_range("a5_latency", vld_cyc - last_t0, 168 * 21 - 21, 168 * 21 + 25);

    send_frame(8'h3C, 1'b1, 1'b1, d96);
    check("3c_data", {24'h0, Rx_DATA}, 32'h3C);
    check("3c_perr", {31'h0, Rx_PERROR}, 32'h1);
    check("3c_strobes", vld_seen, 32'd0);

    fork
      send_frame(8'h81, 1'b0, 1'b0, d96);
      begin
        step(10);
        check("perr_clr_at_start", {31'h0, Rx_PERROR}, 32'h0);
      end
    join
    check("81_ferr", {31'h0, Rx_FERROR}, 32'h1);
    check("81_perr", {31'h0, Rx_PERROR}, 32'h0);
    check("81_strobes", vld_seen, 32'd0);
    step(40 * d96);
    check("low_line_ferr_held", {31'h0, Rx_FERROR}, 32'h1);
    RxD = 1'b1;
    step(20 * d96);
    send_frame(8'h5A, 1'b0, 1'b1, d96);
    check("5a_data", {24'h0, Rx_DATA}, 32'h5A);
    check("5a_strobes", vld_seen, 32'd1);

    for (int sel = 2; sel <= 6; sel++) begin
      logic [7:0] b;
      b = 8'h30 + 8'(sel);
      baud_select = 3'(sel);
      step(20);
      send_frame(b, ^b, 1'b1, baud_div(sel));
      check("sweep_strobes", vld_seen, 32'd1);
    end

    baud_select = 3'd7;
    step(20);
    RxD = 1'b0;
    mark_start();
    step(4 * d115);
    RxD = 1'b1;
    step(40 * d115);
    check("glitch_data", {24'h0, Rx_DATA}, 32'h36);
    send_frame(8'h00, 1'b0, 1'b1, d115);
    check("b2b_00_strobes", vld_seen, 32'd1);
    send_frame(8'hFF, 1'b0, 1'b1, d115);
    check("b2b_ff_data", {24'h0, Rx_DATA}, 32'hFF);
    check("b2b_ff_strobes", vld_seen, 32'd1);

    baud_select = 3'd3;
    step(20);
    send_partial(8'h55, d96);
    Rx_EN = 1'b0;
    RxD   = 1'b1;
    step(40 * d96);
    check("en_off_data", {24'h0, Rx_DATA}, 32'hFF);
    Rx_EN = 1'b1;
    step(20 * d96);
    send_frame(8'h12, 1'b0, 1'b1, d96);
    check("en_12_data", {24'h0, Rx_DATA}, 32'h12);
    check("en_12_strobes", vld_seen, 32'd1);

    send_partial(8'h55, d96);
    reset      = 1'b1;
    RxD        = 1'b1;
    m_data     = 8'h00;
    m_perr     = 1'b0;
    m_ferr     = 1'b0;
    hold_until = cyc + 2;
    step(5);
    check("midrst_data", {24'h0, Rx_DATA}, 32'h0);
    reset = 1'b0;
    step(20 * d96);
    send_frame(8'h12, 1'b0, 1'b1, d96);
    check("rst_12_data", {24'h0, Rx_DATA}, 32'h12);
    check("rst_12_strobes", vld_seen, 32'd1);
    step(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
